md_sched: RTL

- Sequencer and owner of the HI/LO resource for the EX stage.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and holds the unit busy for a fixed multi-cycle latency.
- Commits results to architectural HI/LO and tells the hazard unit when an E-stage HI/LO user must stall.
- Replaces the ad-hoc HI_WE/LO_WE/BUSY handling around the extended ALU with a single controller.

---
 rtl/md_sched_pkg.sv | 29 ++
 rtl/md_sched_if.sv | 29 ++
 rtl/md_sched_arith.sv | 42 ++++
 rtl/md_sched.sv | 118 +++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes,
// FSM states, default latencies and the arithmetic result bundle.
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_S_IDLE = 2'd0,
        MD_S_MULT = 2'd1,
        MD_S_DIV  = 2'd2
    } md_state_e;

    localparam int MD_MULT_CYC_DEF = 5;
    localparam int MD_DIV_CYC_DEF  = 10;
    localparam int MD_CNT_W_DEF    = 4;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_sched_if.sv
// E-stage <-> md_sched handshake: issue request, hazard query, HI/LO read.
interface md_sched_if;
    import md_sched_pkg::*;

    logic        start;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        md_use;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        div0;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport master (
        output start, op, a, b, cancel, md_use, rd_sel,
        input  rd_data, busy, stall, div0, hi_q, lo_q
    );

    modport slave (
        input  start, op, a, b, cancel, md_use, rd_sel,
        output rd_data, busy, stall, div0, hi_q, lo_q
    );

endinterface

// File: rtl/md_sched_arith.sv
// Combinational 64-bit product and quotient/remainder for the HI/LO unit.
// Signed division works on magnitudes, so INT_MIN/-1 wraps to INT_MIN.
module md_arith
    import md_sched_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_res_t     res
);

    logic        mul_sgn, div_sgn, a_neg, b_neg;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    always_comb begin
        mul_sgn = (op == MD_MULT);
        div_sgn = (op == MD_DIV);

        // Low 64 bits of an unsigned multiply of extended operands equal the signed product.
        a_ext = mul_sgn ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = mul_sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;

        a_neg = div_sgn & a[31];
        b_neg = div_sgn & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
        quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;

        res = '0;
        case (op)
            MD_MULT, MD_MULTU: res = '{hi: prod[63:32], lo: prod[31:0]};
            MD_DIV, MD_DIVU:   res = '{hi: rem, lo: quo};
            default:           res = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO owner for EX: accepts mult/div/mthi/mtlo, holds busy for a fixed
// latency, commits to HI/LO and raises stall for E-stage HI/LO users.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC_DEF,
    parameter int DIV_CYC  = MD_DIV_CYC_DEF,
    parameter int CNT_W    = MD_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        z_q, z_d, div0_q, div0_d;
    logic        accept, busy, done;
    md_res_t     arith_res;

    md_arith u_arith (
        .op  (bus.op),
        .a   (bus.a),
        .b   (bus.b),
        .res (arith_res)
    );

    assign accept = bus.start & ~bus.cancel & (state_q == MD_S_IDLE);
    assign done   = (state_q != MD_S_IDLE) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            z_q       <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            z_q       <= z_d;
            div0_q    <= div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_S_IDLE: begin
                if (accept) begin
                    if (bus.op == MD_MULT || bus.op == MD_MULTU) state_d = MD_S_MULT;
                    else if (bus.op == MD_DIV || bus.op == MD_DIVU) state_d = MD_S_DIV;
                end
            end
            MD_S_MULT, MD_S_DIV: if (cnt_q == '0) state_d = MD_S_IDLE;
            default: state_d = MD_S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != MD_S_IDLE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        z_d       = z_q;
        div0_d    = 1'b0;
        if (accept) begin
            case (bus.op)
                MD_MTHI: hi_d = bus.a;
                MD_MTLO: lo_d = bus.a;
                MD_MULT, MD_MULTU: begin
                    pend_hi_d = arith_res.hi;
                    pend_lo_d = arith_res.lo;
                    cnt_d     = CNT_W'(MULT_CYC - 1);
                    z_d       = 1'b0;
                end
                MD_DIV, MD_DIVU: begin
                    pend_hi_d = arith_res.hi;
                    pend_lo_d = arith_res.lo;
                    cnt_d     = CNT_W'(DIV_CYC - 1);
                    z_d       = (bus.b == 32'd0);
                end
                default: ;
            endcase
        end else if (done) begin
            // A divide by zero leaves HI/LO untouched and only reports via div0.
            if (!(state_q == MD_S_DIV && z_q)) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
            div0_d = (state_q == MD_S_DIV) & z_q;
        end else if (state_q != MD_S_IDLE) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
    assign bus.busy    = busy;
    assign bus.stall   = bus.md_use & busy;
    assign bus.div0    = div0_q;
    assign bus.hi_q    = hi_q;
    assign bus.lo_q    = lo_q;

endmodule
